regfile_access_arbiter: RTL and testbench
=========================================

# regfile_access_arbiter

Shares the dmawr register file between two bus masters: the host register port (requester A) and the local DMA/validation master (requester B). Grants one transaction at a time, round-robin, and routes it either to the internal register bank (fixed one-cycle read latency) or to the external section port (variable latency, ready handshake). External accesses are protected by a timeout. It sits between the host interface and the generated register file, where it serializes all register traffic.

## Interface

Parameters:
- ADDR_W, 12, byte address width (bits [1:0] passed through unchanged)
- EXT_BASE, 12'h800, addresses >= EXT_BASE go to the external port; lower addresses go to the internal bank
- TIMEOUT, 16, maximum cycles an external strobe waits for ext_ready (legal range 2..255)

Ports (x = a or b):
- sysclk  in  1  single clock; all logic is rising-edge
- sysrst_n  in  1  asynchronous, active-low reset
- x_req  in  1  level request; held until x_ack
- x_wr  in  1  1 = write, 0 = read; stable while x_req
- x_addr  in  ADDR_W  byte address; stable while x_req
- x_be  in  4  byte enables
- x_wdata  in  32  write data
- x_ack  out  1  one-cycle completion pulse
- x_rdata  out  32  read data; valid with x_ack
- x_err  out  1  timeout flag; valid with x_ack
- reg_read, reg_write  out  1  internal strobes; one cycle each
- reg_addr  out  ADDR_W; reg_be  out  4; reg_wdata  out  32
- reg_rdata  in  32  valid the cycle after reg_read
- ext_read, ext_write  out  1  external strobes; held until ready or timeout
- ext_addr  out  ADDR_W; ext_be  out  4; ext_wdata  out  32
- ext_rdata  in  32  sampled in the cycle ext_ready=1
- ext_ready  in  1  external completion
- busy  out  1  high in every non-IDLE state
- timeout_evt  out  1  one-cycle pulse when a timeout completes

## Operation

- States:
  - IDLE
  - ISSUE: internal strobe cycle
  - RDWAIT: internal read capture
  - EXT: external strobe held
  - ACK
- IDLE: if any request is pending, pick the winner, latch its wr/addr/be/wdata, and go to ISSUE. Otherwise stay in IDLE.
- Round-robin: a `last` register records the previously granted requester.
  - If only one requester is asking, that one is granted.
  - If both are asking, the one not equal to `last` is granted.
  - `last` resets to B, so A wins the first simultaneous contest.
- Decode: latched addr < EXT_BASE selects internal, otherwise external. The decision is made once, at grant.
- Internal path:
  - ISSUE asserts reg_write or reg_read for exactly one cycle.
  - A write then goes to ACK.
  - A read goes to RDWAIT, captures reg_rdata, then goes to ACK.
- External path:
  - EXT asserts ext_write or ext_read continuously, and a counter runs from 0.
  - If ext_ready=1 in that cycle: drop the strobe, capture ext_rdata (read), err=0, go to ACK.
  - Else, if the count reaches TIMEOUT-1: drop the strobe, set rdata=32'hDEAD_BEEF and err=1, pulse timeout_evt, go to ACK.
- ACK:
  - Pulse the granted requester's x_ack, with x_rdata/x_err.
  - Write completions return rdata=0.
  - Go to IDLE.
  - Requests are not sampled in ACK. A requester must drop x_req in the cycle after x_ack, otherwise IDLE starts a new transaction.
- The non-granted requester's ack, rdata and err stay 0.
- be=4'h0 is still issued as a strobe; the target ignores the data.
- Reset (asynchronous, any state):
  - state=IDLE, last=B, counter=0.
  - All outputs are 0, including rdata and addr/data buses.
  - An in-flight transaction is dropped with no ack.

## Timing

- All outputs are registered.
- Internal write: request sampled at edge 0 → reg_write high in cycle 1 → x_ack in cycle 2. Latency is 2 cycles.
- Internal read: reg_read in cycle 1, reg_rdata valid in cycle 2 → x_ack with data in cycle 3.
- External: strobe starts in cycle 1. If ext_ready is high in cycle k (k ≥ 1), x_ack occurs in cycle k+1.
- Timeout: the strobe is high for exactly TIMEOUT cycles (cycles 1..TIMEOUT), then x_ack/x_err/timeout_evt in cycle TIMEOUT+1.
- If ext_ready=1 in the same cycle the count reaches TIMEOUT-1, the access completes as a success.
- Back-to-back: the next grant is sampled in the IDLE cycle following ACK. Minimum spacing is 3 cycles per internal write.

## Test plan

- Reset checks:
  - Reset is asserted → every output is 0.
  - Release reset, then A writes 0x1234_5678 to 0x010 → reg_write=1 for one cycle with addr 0x010, be 0xF → a_ack 2 cycles after request, err=0.
- Internal read: B reads 0x020 while reg_rdata=0xCAFE_0001 the cycle after reg_read → b_ack 3 cycles after request with b_rdata=0xCAFE_0001; a_ack stays 0.
- Simultaneous requests: A and B request on the same edge after reset → A is served first, then B. Keep both requests held for 4 transactions → grants alternate A, B, A, B.
- External read: read of 0x804 with ext_ready high on strobe cycle 3 and ext_rdata=0x0000_BEEF → ack in cycle 4, rdata 0x0000_BEEF, err=0. Also ready on the first strobe cycle → ack in cycle 2.
- Timeout: TIMEOUT=16, ext_ready never asserted → strobe high for 16 cycles, then ack with rdata=0xDEAD_BEEF, err=1, and a timeout_evt pulse. Ready arriving on strobe cycle 16 → success, err=0.
- Reset mid-operation: assert sysrst_n=0 during an EXT strobe → strobe and busy go to 0 immediately with no ack. After release, a fresh A write completes normally.

Source files
------------

// File: rtl/regfile_access_arbiter.sv
// Round-robin arbiter serializing two bus masters onto the dmawr register file:
// internal bank (one-cycle read latency) or external section port (ready handshake, timeout).
module regfile_access_arbiter #(
    parameter int                ADDR_W   = 12,
    parameter logic [ADDR_W-1:0] EXT_BASE = 'h800,
    parameter int                TIMEOUT  = 16
) (
    input  logic              sysclk,
    input  logic              sysrst_n,
    input  logic              a_req,
    input  logic              a_wr,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [3:0]        a_be,
    input  logic [31:0]       a_wdata,
    output logic              a_ack,
    output logic [31:0]       a_rdata,
    output logic              a_err,
    input  logic              b_req,
    input  logic              b_wr,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [3:0]        b_be,
    input  logic [31:0]       b_wdata,
    output logic              b_ack,
    output logic [31:0]       b_rdata,
    output logic              b_err,
    output logic              reg_read,
    output logic              reg_write,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [3:0]        reg_be,
    output logic [31:0]       reg_wdata,
    input  logic [31:0]       reg_rdata,
    output logic              ext_read,
    output logic              ext_write,
    output logic [ADDR_W-1:0] ext_addr,
    output logic [3:0]        ext_be,
    output logic [31:0]       ext_wdata,
    input  logic [31:0]       ext_rdata,
    input  logic              ext_ready,
    output logic              busy,
    output logic              timeout_evt,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_RDWAIT = 3'd2,
        S_EXT    = 3'd3,
        S_ACK    = 3'd4
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    // Handshake: a master raises x_req with wr/addr/be/wdata stable and holds it
    // until the single-cycle x_ack; rdata/err are valid only in that ack cycle.

    state_t            r_state, w_state_nxt;
    logic              r_last, w_last_nxt;     // 1 = B was granted last
    logic              r_gnt_b, w_gnt_b_nxt;   // owner of the transaction in flight
    logic              r_wr, w_wr_nxt;
    logic [7:0]        r_cnt, w_cnt_nxt;

    logic              r_reg_read, r_reg_write, w_reg_read_nxt, w_reg_write_nxt;
    logic [ADDR_W-1:0] r_reg_addr, w_reg_addr_nxt;
    logic [3:0]        r_reg_be, w_reg_be_nxt;
    logic [31:0]       r_reg_wdata, w_reg_wdata_nxt;
    logic              r_ext_read, r_ext_write, w_ext_read_nxt, w_ext_write_nxt;
    logic [ADDR_W-1:0] r_ext_addr, w_ext_addr_nxt;
    logic [3:0]        r_ext_be, w_ext_be_nxt;
    logic [31:0]       r_ext_wdata, w_ext_wdata_nxt;

    logic              r_a_ack, r_b_ack, r_a_err, r_b_err;
    logic [31:0]       r_a_rdata, r_b_rdata;
    logic              r_busy, r_timeout_evt;

    logic              w_done, w_done_err, w_timeout;
    logic [31:0]       w_done_rdata;

    logic              w_any, w_gnt_b, w_sel_wr, w_sel_ext;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [3:0]        w_sel_be;
    logic [31:0]       w_sel_wdata;

    always_comb begin
        w_any       = a_req || b_req;
        w_gnt_b     = b_req && (!a_req || !r_last);
        w_sel_wr    = w_gnt_b ? b_wr    : a_wr;
        w_sel_addr  = w_gnt_b ? b_addr  : a_addr;
        w_sel_be    = w_gnt_b ? b_be    : a_be;
        w_sel_wdata = w_gnt_b ? b_wdata : a_wdata;
        w_sel_ext   = (w_sel_addr >= EXT_BASE);
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_last_nxt      = r_last;
        w_gnt_b_nxt     = r_gnt_b;
        w_wr_nxt        = r_wr;
        w_cnt_nxt       = r_cnt;
        w_reg_read_nxt  = 1'b0;
        w_reg_write_nxt = 1'b0;
        w_reg_addr_nxt  = r_reg_addr;
        w_reg_be_nxt    = r_reg_be;
        w_reg_wdata_nxt = r_reg_wdata;
        w_ext_read_nxt  = 1'b0;
        w_ext_write_nxt = 1'b0;
        w_ext_addr_nxt  = r_ext_addr;
        w_ext_be_nxt    = r_ext_be;
        w_ext_wdata_nxt = r_ext_wdata;
        w_done          = 1'b0;
        w_done_rdata    = 32'h0;
        w_done_err      = 1'b0;
        w_timeout       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_gnt_b_nxt = w_gnt_b;
                    w_last_nxt  = w_gnt_b;
                    w_wr_nxt    = w_sel_wr;
                    w_cnt_nxt   = 8'd0;
                    if (w_sel_ext) begin
                        w_state_nxt     = S_EXT;
                        w_ext_read_nxt  = !w_sel_wr;
                        w_ext_write_nxt = w_sel_wr;
                        w_ext_addr_nxt  = w_sel_addr;
                        w_ext_be_nxt    = w_sel_be;
                        w_ext_wdata_nxt = w_sel_wdata;
                    end else begin
                        w_state_nxt     = S_ISSUE;
                        w_reg_read_nxt  = !w_sel_wr;
                        w_reg_write_nxt = w_sel_wr;
                        w_reg_addr_nxt  = w_sel_addr;
                        w_reg_be_nxt    = w_sel_be;
                        w_reg_wdata_nxt = w_sel_wdata;
                    end
                end
            end
            S_ISSUE: begin
                if (r_wr) begin
                    w_state_nxt = S_ACK;
                    w_done      = 1'b1;
                end else begin
                    w_state_nxt = S_RDWAIT;
                end
            end
            S_RDWAIT: begin
                w_state_nxt  = S_ACK;
                w_done       = 1'b1;
                w_done_rdata = reg_rdata;
            end
            S_EXT: begin
                // ready wins over a timeout landing in the same cycle
                if (ext_ready) begin
                    w_state_nxt  = S_ACK;
                    w_done       = 1'b1;
                    w_done_rdata = r_wr ? 32'h0 : ext_rdata;
                end else if (r_cnt == TO_LAST) begin
                    w_state_nxt  = S_ACK;
                    w_done       = 1'b1;
                    w_done_rdata = 32'hDEAD_BEEF;
                    w_done_err   = 1'b1;
                    w_timeout    = 1'b1;
                end else begin
                    w_ext_read_nxt  = r_ext_read;
                    w_ext_write_nxt = r_ext_write;
                    w_cnt_nxt       = r_cnt + 8'd1;
                end
            end
            S_ACK: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sysclk or negedge sysrst_n) begin
        if (!sysrst_n) begin
            r_state       <= S_IDLE;
            r_last        <= 1'b1;
            r_gnt_b       <= 1'b0;
            r_wr          <= 1'b0;
            r_cnt         <= 8'd0;
            r_reg_read    <= 1'b0;
            r_reg_write   <= 1'b0;
            r_reg_addr    <= '0;
            r_reg_be      <= 4'h0;
            r_reg_wdata   <= 32'h0;
            r_ext_read    <= 1'b0;
            r_ext_write   <= 1'b0;
            r_ext_addr    <= '0;
            r_ext_be      <= 4'h0;
            r_ext_wdata   <= 32'h0;
            r_a_ack       <= 1'b0;
            r_a_rdata     <= 32'h0;
            r_a_err       <= 1'b0;
            r_b_ack       <= 1'b0;
            r_b_rdata     <= 32'h0;
            r_b_err       <= 1'b0;
            r_busy        <= 1'b0;
            r_timeout_evt <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_last        <= w_last_nxt;
            r_gnt_b       <= w_gnt_b_nxt;
            r_wr          <= w_wr_nxt;
            r_cnt         <= w_cnt_nxt;
            r_reg_read    <= w_reg_read_nxt;
            r_reg_write   <= w_reg_write_nxt;
            r_reg_addr    <= w_reg_addr_nxt;
            r_reg_be      <= w_reg_be_nxt;
            r_reg_wdata   <= w_reg_wdata_nxt;
            r_ext_read    <= w_ext_read_nxt;
            r_ext_write   <= w_ext_write_nxt;
            r_ext_addr    <= w_ext_addr_nxt;
            r_ext_be      <= w_ext_be_nxt;
            r_ext_wdata   <= w_ext_wdata_nxt;
            r_a_ack       <= w_done && !r_gnt_b;
            r_a_rdata     <= (w_done && !r_gnt_b) ? w_done_rdata : 32'h0;
            r_a_err       <= w_done && !r_gnt_b && w_done_err;
            r_b_ack       <= w_done && r_gnt_b;
            r_b_rdata     <= (w_done && r_gnt_b) ? w_done_rdata : 32'h0;
            r_b_err       <= w_done && r_gnt_b && w_done_err;
            r_busy        <= (w_state_nxt != S_IDLE);
            r_timeout_evt <= w_timeout;
        end
    end

    assign a_ack       = r_a_ack;
    assign a_rdata     = r_a_rdata;
    assign a_err       = r_a_err;
    assign b_ack       = r_b_ack;
    assign b_rdata     = r_b_rdata;
    assign b_err       = r_b_err;
    assign reg_read    = r_reg_read;
    assign reg_write   = r_reg_write;
    assign reg_addr    = r_reg_addr;
    assign reg_be      = r_reg_be;
    assign reg_wdata   = r_reg_wdata;
    assign ext_read    = r_ext_read;
    assign ext_write   = r_ext_write;
    assign ext_addr    = r_ext_addr;
    assign ext_be      = r_ext_be;
    assign ext_wdata   = r_ext_wdata;
    assign busy        = r_busy;
    assign timeout_evt = r_timeout_evt;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// Directed bench for regfile_access_arbiter: internal/external paths, round-robin, timeout, reset.
module tb_regfile_access_arbiter;

    localparam int ADDR_W = 12;

    logic              sysclk, sysrst_n;
    logic              a_req, a_wr, b_req, b_wr;
    logic [ADDR_W-1:0] a_addr, b_addr;
    logic [3:0]        a_be, b_be;
    logic [31:0]       a_wdata, b_wdata;
    logic              a_ack, a_err, b_ack, b_err;
    logic [31:0]       a_rdata, b_rdata;
    logic              reg_read, reg_write;
    logic [ADDR_W-1:0] reg_addr;
    logic [3:0]        reg_be;
    logic [31:0]       reg_wdata, reg_rdata;
    logic              ext_read, ext_write;
    logic [ADDR_W-1:0] ext_addr;
    logic [3:0]        ext_be;
    logic [31:0]       ext_wdata, ext_rdata;
    logic              ext_ready, busy, timeout_evt;
    logic [2:0]        dbg_state;

    int checks = 0;
    int errors = 0;

    regfile_access_arbiter #(.ADDR_W(ADDR_W), .EXT_BASE(12'h800), .TIMEOUT(16)) dut (
        .sysclk(sysclk), .sysrst_n(sysrst_n),
        .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_be(a_be), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata), .a_err(a_err),
        .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_be(b_be), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata), .b_err(b_err),
        .reg_read(reg_read), .reg_write(reg_write), .reg_addr(reg_addr), .reg_be(reg_be),
        .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
        .ext_read(ext_read), .ext_write(ext_write), .ext_addr(ext_addr), .ext_be(ext_be),
        .ext_wdata(ext_wdata), .ext_rdata(ext_rdata), .ext_ready(ext_ready),
        .busy(busy), .timeout_evt(timeout_evt), .dbg_state(dbg_state)
    );

    // clock / reset
    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    task automatic clear_inputs();
        a_req = 0; a_wr = 0; a_addr = '0; a_be = 0; a_wdata = 0;
        b_req = 0; b_wr = 0; b_addr = '0; b_be = 0; b_wdata = 0;
        reg_rdata = 0; ext_rdata = 0; ext_ready = 0;
    endtask

    task automatic do_reset();
        sysrst_n = 0;
        step(); step();
        sysrst_n = 1;
        step();
    endtask

    task automatic test_reset();
        logic [31:0] all_out;
        sysrst_n = 0;
        a_req = 1; a_wr = 1; a_addr = 12'h010; a_be = 4'hF; a_wdata = 32'hFFFF_FFFF;
        b_req = 1; b_addr = 12'h900; reg_rdata = 32'h1111_1111; ext_rdata = 32'h2222_2222;
        step(); step(); step();
        all_out = a_rdata | b_rdata | reg_wdata | ext_wdata | 32'(reg_addr) | 32'(ext_addr);
        checks++;
        if (all_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_buses: got %h expected 0", all_out);
        end
        checks++;
        if ({a_ack, a_err, b_ack, b_err, reg_read, reg_write, reg_be, ext_read, ext_write,
             ext_be, busy, timeout_evt, dbg_state} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: ack=%b%b rd/wr=%b%b ext=%b%b busy=%b state=%0d expected all 0",
                     a_ack, b_ack, reg_read, reg_write, ext_read, ext_write, busy, dbg_state);
        end
        clear_inputs();
        sysrst_n = 1;
        step();
    endtask

    task automatic test_int_write();
        a_req = 1; a_wr = 1; a_addr = 12'h010; a_be = 4'hF; a_wdata = 32'h1234_5678;
        step();
        checks++;
        if ({reg_write, reg_read, busy, a_ack} !== 4'b1010 || reg_addr !== 12'h010 ||
            reg_be !== 4'hF || reg_wdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL int_wr_strobe: wr=%b rd=%b busy=%b ack=%b addr=%h be=%h data=%h expected 1 0 1 0 010 f 12345678",
                     reg_write, reg_read, busy, a_ack, reg_addr, reg_be, reg_wdata);
        end
        step();
        checks++;
        if ({reg_write, a_ack, a_err, b_ack} !== 4'b0100 || a_rdata !== 32'h0) begin
            errors++;
            $display("FAIL int_wr_ack: wr=%b a_ack=%b a_err=%b b_ack=%b rdata=%h expected 0 1 0 0 0",
                     reg_write, a_ack, a_err, b_ack, a_rdata);
        end
        a_req = 0;
        step();
        checks++;
        if (a_ack !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL int_wr_done: a_ack=%b busy=%b expected 0 0", a_ack, busy);
        end
    endtask

    task automatic test_int_read();
        b_req = 1; b_wr = 0; b_addr = 12'h020; b_be = 4'hF;
        reg_rdata = 32'h0BAD_0BAD;
        step();
        checks++;
        if (reg_read !== 1'b1 || reg_write !== 1'b0 || reg_addr !== 12'h020) begin
            errors++;
            $display("FAIL int_rd_strobe: rd=%b wr=%b addr=%h expected 1 0 020", reg_read, reg_write, reg_addr);
        end
        step();
        reg_rdata = 32'hCAFE_0001;
        checks++;
        if (reg_read !== 1'b0 || b_ack !== 1'b0) begin
            errors++;
            $display("FAIL int_rd_wait: rd=%b b_ack=%b expected 0 0", reg_read, b_ack);
        end
        step();
        reg_rdata = 32'h0BAD_0BAD;
        checks++;
        if (b_ack !== 1'b1 || b_rdata !== 32'hCAFE_0001 || b_err !== 1'b0 ||
            a_ack !== 1'b0 || a_rdata !== 32'h0) begin
            errors++;
            $display("FAIL int_rd_ack: b_ack=%b b_rdata=%h b_err=%b a_ack=%b a_rdata=%h expected 1 cafe0001 0 0 0",
                     b_ack, b_rdata, b_err, a_ack, a_rdata);
        end
        b_req = 0;
        reg_rdata = 0;
        step();
    endtask

    task automatic test_be_zero();
        a_req = 1; a_wr = 1; a_addr = 12'h044; a_be = 4'h0; a_wdata = 32'h0000_00AA;
        step();
        checks++;
        if (reg_write !== 1'b1 || reg_be !== 4'h0 || reg_addr !== 12'h044) begin
            errors++;
            $display("FAIL be_zero_strobe: wr=%b be=%h addr=%h expected 1 0 044", reg_write, reg_be, reg_addr);
        end
        step();
        a_req = 0;
        step();
    endtask

    task automatic test_round_robin();
        logic [3:0] seq;
        int n;
        do_reset();
        seq = 4'h0;
        n = 0;
        a_req = 1; a_wr = 1; a_addr = 12'h100; a_be = 4'hF; a_wdata = 32'hAAAA_0000;
        b_req = 1; b_wr = 1; b_addr = 12'h200; b_be = 4'hF; b_wdata = 32'hBBBB_0000;
        for (int cyc = 0; cyc < 30 && n < 4; cyc++) begin
            step();
            if (a_ack && b_ack) begin
                checks++;
                errors++;
                $display("FAIL rr_dual_ack: both acks high at cycle %0d expected one", cyc);
            end
            if (a_ack || b_ack) begin
                seq[n] = b_ack;
                n++;
                if (n == 4) begin
                    a_req = 0;
                    b_req = 0;
                end
            end
        end
        checks++;
        if (n != 4 || seq !== 4'b1010) begin
            errors++;
            $display("FAIL rr_order: got %0d grants order %b expected 4 grants order 1010 (bit0 first, 1=B)", n, seq);
        end
        step(); step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rr_idle: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_ext_read();
        a_req = 1; a_wr = 0; a_addr = 12'h804; a_be = 4'hF;
        ext_rdata = 32'h1357_9BDF;
        step();
        checks++;
        if (ext_read !== 1'b1 || ext_write !== 1'b0 || reg_read !== 1'b0 || ext_addr !== 12'h804) begin
            errors++;
            $display("FAIL ext_rd_strobe: ext_rd=%b ext_wr=%b reg_rd=%b addr=%h expected 1 0 0 804",
                     ext_read, ext_write, reg_read, ext_addr);
        end
        step();
        step();
        ext_ready = 1; ext_rdata = 32'h0000_BEEF;
        checks++;
        if (ext_read !== 1'b1 || a_ack !== 1'b0) begin
            errors++;
            $display("FAIL ext_rd_hold: ext_rd=%b a_ack=%b expected 1 0", ext_read, a_ack);
        end
        step();
        ext_ready = 0; ext_rdata = 0;
        checks++;
        if (ext_read !== 1'b0 || a_ack !== 1'b1 || a_rdata !== 32'h0000_BEEF ||
            a_err !== 1'b0 || timeout_evt !== 1'b0) begin
            errors++;
            $display("FAIL ext_rd_ack: ext_rd=%b a_ack=%b rdata=%h err=%b tevt=%b expected 0 1 0000beef 0 0",
                     ext_read, a_ack, a_rdata, a_err, timeout_evt);
        end
        a_req = 0;
        step();

        b_req = 1; b_wr = 1; b_addr = 12'h900; b_be = 4'h3; b_wdata = 32'h5A5A_A5A5;
        step();
        ext_ready = 1; ext_rdata = 32'hFFFF_FFFF;
        checks++;
        if (ext_write !== 1'b1 || ext_addr !== 12'h900 || ext_be !== 4'h3 || ext_wdata !== 32'h5A5A_A5A5) begin
            errors++;
            $display("FAIL ext_wr_strobe: wr=%b addr=%h be=%h data=%h expected 1 900 3 5a5aa5a5",
                     ext_write, ext_addr, ext_be, ext_wdata);
        end
        step();
        ext_ready = 0; ext_rdata = 0;
        checks++;
        if (b_ack !== 1'b1 || b_rdata !== 32'h0 || b_err !== 1'b0 || ext_write !== 1'b0 || a_ack !== 1'b0) begin
            errors++;
            $display("FAIL ext_wr_ack: b_ack=%b b_rdata=%h b_err=%b ext_wr=%b a_ack=%b expected 1 0 0 0 0",
                     b_ack, b_rdata, b_err, ext_write, a_ack);
        end
        b_req = 0;
        step();
    endtask

    task automatic test_timeout();
        int strobes, ack_cyc;
        strobes = 0; ack_cyc = 0;
        a_req = 1; a_wr = 0; a_addr = 12'hA00; a_be = 4'hF;
        for (int k = 1; k <= 40 && ack_cyc == 0; k++) begin
            step();
            if (ext_read) strobes++;
            if (a_ack) begin
                ack_cyc = k;
                a_req = 0;
                checks++;
                if (a_rdata !== 32'hDEAD_BEEF || a_err !== 1'b1 || timeout_evt !== 1'b1 || ext_read !== 1'b0) begin
                    errors++;
                    $display("FAIL to_ack: rdata=%h err=%b tevt=%b ext_rd=%b expected deadbeef 1 1 0",
                             a_rdata, a_err, timeout_evt, ext_read);
                end
            end
        end
        checks++;
        if (ack_cyc != 17 || strobes != 16) begin
            errors++;
            $display("FAIL to_timing: ack cycle %0d strobes %0d expected 17 16", ack_cyc, strobes);
        end
        step();
        checks++;
        if (timeout_evt !== 1'b0 || a_ack !== 1'b0) begin
            errors++;
            $display("FAIL to_pulse: tevt=%b a_ack=%b expected 0 0", timeout_evt, a_ack);
        end

        strobes = 0; ack_cyc = 0;
        a_req = 1;
        for (int k = 1; k <= 40 && ack_cyc == 0; k++) begin
            step();
            ext_ready = 0;
            if (ext_read) strobes++;
            if (a_ack) begin
                ack_cyc = k;
                a_req = 0;
                checks++;
                if (a_rdata !== 32'h55AA_1234 || a_err !== 1'b0 || timeout_evt !== 1'b0) begin
                    errors++;
                    $display("FAIL to_late_ready: rdata=%h err=%b tevt=%b expected 55aa1234 0 0",
                             a_rdata, a_err, timeout_evt);
                end
            end
            if (k == 16) begin
                ext_ready = 1;
                ext_rdata = 32'h55AA_1234;
            end
        end
        ext_ready = 0; ext_rdata = 0;
        checks++;
        if (ack_cyc != 17 || strobes != 16) begin
            errors++;
            $display("FAIL to_late_timing: ack cycle %0d strobes %0d expected 17 16", ack_cyc, strobes);
        end
        step();
    endtask

    task automatic test_reset_mid();
        int acks;
        acks = 0;
        a_req = 1; a_wr = 0; a_addr = 12'hC00; a_be = 4'hF;
        for (int k = 0; k < 5; k++) step();
        checks++;
        if (ext_read !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre: ext_rd=%b busy=%b expected 1 1", ext_read, busy);
        end
        #2;
        sysrst_n = 0;
        #1;
        checks++;
        if (ext_read !== 1'b0 || busy !== 1'b0 || a_ack !== 1'b0 || dbg_state !== 3'd0) begin
            errors++;
            $display("FAIL mid_async: ext_rd=%b busy=%b a_ack=%b state=%0d expected 0 0 0 0",
                     ext_read, busy, a_ack, dbg_state);
        end
        a_req = 0;
        step();
        sysrst_n = 1;
        for (int k = 0; k < 4; k++) begin
            step();
            if (a_ack || b_ack) acks++;
        end
        checks++;
        if (acks != 0) begin
            errors++;
            $display("FAIL mid_no_ack: %0d acks after reset expected 0", acks);
        end
        a_req = 1; a_wr = 1; a_addr = 12'h030; a_be = 4'hC; a_wdata = 32'h0F0F_0F0F;
        step();
        step();
        checks++;
        if (a_ack !== 1'b1 || a_err !== 1'b0 || reg_addr !== 12'h030 || reg_wdata !== 32'h0F0F_0F0F) begin
            errors++;
            $display("FAIL mid_recover: a_ack=%b err=%b addr=%h data=%h expected 1 0 030 0f0f0f0f",
                     a_ack, a_err, reg_addr, reg_wdata);
        end
        a_req = 0;
        step();
    endtask

    initial begin
        clear_inputs();
        sysrst_n = 0;
        test_reset();
        test_int_write();
        test_int_read();
        test_be_zero();
        test_round_robin();
        test_ext_read();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
